// File: rtl/axi_vga_capture_pkg.sv
// Shared types for the VGA capture path: pixel layout, FSM states
// and the AXI4 write-master bundles.
package axi_vga_capture_pkg;

  localparam int unsigned RedW       = 5;
  localparam int unsigned GreenW     = 6;
  localparam int unsigned BlueW      = 5;
  localparam int unsigned PixW       = RedW + GreenW + BlueW;
  localparam int unsigned AddrW      = 64;
  localparam int unsigned DataW      = 64;
  localparam int unsigned StrbW      = DataW / 8;
  localparam int unsigned PixPerWord = DataW / PixW;
  localparam int unsigned FifoD      = 32;

  typedef struct packed {
    logic [RedW-1:0]   r;
    logic [GreenW-1:0] g;
    logic [BlueW-1:0]  b;
  } pix_t;

  typedef enum logic [2:0] {
    F_IDLE,
    F_ARMED,
    F_CAPTURE,
    F_DRAIN,
    F_FLUSH
  } frame_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_AW,
    W_W,
    W_B
  } wr_state_e;

  typedef struct packed {
    logic [3:0]       aw_id;
    logic [AddrW-1:0] aw_addr;
    logic [7:0]       aw_len;
    logic [2:0]       aw_size;
    logic [1:0]       aw_burst;
    logic [3:0]       aw_cache;
    logic [2:0]       aw_prot;
    logic             aw_valid;
    logic [DataW-1:0] w_data;
    logic [StrbW-1:0] w_strb;
    logic             w_last;
    logic             w_valid;
    logic             b_ready;
    logic             ar_valid;
    logic             r_ready;
  } cap_axi_req_t;

  typedef struct packed {
    logic       aw_ready;
    logic       w_ready;
    logic       b_valid;
    logic [1:0] b_resp;
  } cap_axi_resp_t;

endpackage

// File: rtl/axi_vga_capture_packer.sv
// Packs consecutive pixels into one AXI word, pixel 0 in the LSBs.
// The finished word is presented for one cycle after its last pixel.
module axi_vga_capture_packer #(
  parameter int unsigned PixWidth  = 16,
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 pix_valid_i,
  input  logic [PixWidth-1:0]  pix_i,
  output logic                 word_valid_o,
  output logic [DataWidth-1:0] word_o
);

  localparam int unsigned PerWord = DataWidth / PixWidth;

  logic [7:0]           cnt_q;
  logic [DataWidth-1:0] acc_q;
  logic [DataWidth-1:0] acc_d;
  logic [DataWidth-1:0] word_q;
  logic                 vld_q;
  logic                 last;

  assign last = cnt_q == 8'(PerWord - 1);

  always_comb begin
    acc_d = acc_q;
    acc_d[cnt_q*PixWidth +: PixWidth] = pix_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else if (clr_i) begin
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (pix_valid_i) begin
        acc_q <= acc_d;
        if (last) begin
          cnt_q  <= '0;
          word_q <= acc_d;
          vld_q  <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

  assign word_valid_o = vld_q;
  assign word_o       = word_q;

endmodule

// File: rtl/axi_vga_capture.sv
// Captures an RGB video stream and writes whole frames to memory
// as AXI4 INCR bursts, one burst outstanding at a time.
module axi_vga_capture
  import axi_vga_capture_pkg::*;
#(
  parameter int unsigned RedWidth     = RedW,
  parameter int unsigned GreenWidth   = GreenW,
  parameter int unsigned BlueWidth    = BlueW,
  parameter int unsigned AXIAddrWidth = AddrW,
  parameter int unsigned AXIDataWidth = DataW,
  parameter int unsigned AXIStrbWidth = StrbW,
  parameter int unsigned FifoDepth    = FifoD,
  parameter type         axi_req_t    = cap_axi_req_t,
  parameter type         axi_resp_t   = cap_axi_resp_t
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic [AXIAddrWidth-1:0] start_addr_i,
  input  logic [31:0]             frame_size_i,
  input  logic [7:0]              burst_len_i,
  input  logic                    vsync_i,
  input  logic                    de_i,
  input  logic                    pix_en_i,
  input  logic [RedWidth-1:0]     red_i,
  input  logic [GreenWidth-1:0]   green_i,
  input  logic [BlueWidth-1:0]    blue_i,
  output axi_req_t                axi_req_o,
  input  axi_resp_t               axi_resp_i,
  output logic                    busy_o,
  output logic                    frame_done_o,
  output logic                    overflow_o,
  output logic                    error_o
);

  localparam int unsigned PixWidth = RedWidth + GreenWidth + BlueWidth;
  localparam int unsigned PtrW     = $clog2(FifoDepth);
  localparam int unsigned CntW     = PtrW + 1;
  localparam int unsigned ShAmt    = $clog2(AXIStrbWidth);
  localparam logic [2:0]  AxSize   = 3'(ShAmt);

  if (AXIDataWidth % PixWidth != 0) begin : g_pixw_chk
    $error("AXIDataWidth must be a multiple of the pixel width");
  end

  frame_state_e fs_q;
  wr_state_e    ws_q;

  logic                    vsync_q;
  logic [AXIAddrWidth-1:0] base_q;
  logic [31:0]             fsize_q;
  logic [7:0]              blen_q;
  logic [31:0]             pushed_q;
  logic [31:0]             dropped_q;
  logic [31:0]             widx_q;
  logic                    done_q;
  logic                    ovf_q;
  logic                    err_q;
  logic [AXIAddrWidth-1:0] aw_addr_q;
  logic [7:0]              aw_len_q;
  logic [2:0]              aw_size_q;
  logic [7:0]              wcnt_q;

  logic [AXIDataWidth-1:0] mem_q [FifoDepth];
  logic [PtrW-1:0]         wptr_q;
  logic [PtrW-1:0]         rptr_q;
  logic [CntW-1:0]         cnt_q;

  pix_t                    pix;
  logic                    cap_active;
  logic                    word_vld;
  logic [AXIDataWidth-1:0] word;
  logic                    push_req;
  logic                    push;
  logic                    drop;
  logic                    pop;
  logic                    full;
  logic                    flush;
  logic                    w_valid;
  logic                    vs_rise;
  logic                    arm_go;
  logic                    last_word;
  logic                    drain_done;
  logic                    b_err;
  logic                    issue;
  logic [31:0]             rem;
  logic [31:0]             bl1;
  logic [31:0]             beats;

  assign pix        = '{r: red_i, g: green_i, b: blue_i};
  assign cap_active = (fs_q == F_CAPTURE) && enable_i;
  assign vs_rise    = vsync_i && !vsync_q;
  assign arm_go     = (fs_q == F_ARMED) && enable_i && vs_rise;

  axi_vga_capture_packer #(
    .PixWidth (PixWidth),
    .DataWidth(AXIDataWidth)
  ) u_packer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (!cap_active),
    .pix_valid_i (cap_active && de_i && pix_en_i),
    .pix_i       (pix),
    .word_valid_o(word_vld),
    .word_o      (word)
  );

  assign w_valid   = ws_q == W_W;
  assign pop       = w_valid && axi_resp_i.w_ready;
  assign full      = cnt_q == CntW'(FifoDepth);
  assign push_req  = word_vld && cap_active;
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && !push;
  assign flush     = (fs_q == F_FLUSH) && (ws_q == W_IDLE);
  assign last_word = push_req && (pushed_q + 32'd1 == fsize_q);
  assign b_err     = (ws_q == W_B) && axi_resp_i.b_valid
                     && (axi_resp_i.b_resp != 2'b00);

  // Dropped words never reach memory, so the write side only
  // expects the words that were actually stored.
  assign rem   = fsize_q - dropped_q - widx_q;
  assign bl1   = 32'(blen_q) + 32'd1;
  assign beats = (rem < bl1) ? rem : bl1;
  assign issue = (ws_q == W_IDLE) && enable_i
                 && (fs_q == F_CAPTURE || fs_q == F_DRAIN)
                 && (rem != 32'd0) && (32'(cnt_q) >= beats);
  assign drain_done = (ws_q == W_IDLE)
                      && (widx_q == fsize_q - dropped_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fs_q      <= F_IDLE;
      vsync_q   <= 1'b0;
      base_q    <= '0;
      fsize_q   <= '0;
      blen_q    <= '0;
      pushed_q  <= '0;
      dropped_q <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
      done_q  <= 1'b0;
      if (push_req) pushed_q <= pushed_q + 32'd1;
      if (drop) begin
        dropped_q <= dropped_q + 32'd1;
        ovf_q     <= 1'b1;
      end
      if (b_err) err_q <= 1'b1;
      unique case (fs_q)
        F_IDLE: begin
          if (enable_i) begin
            fs_q  <= F_ARMED;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
          end
        end
        F_ARMED: begin
          if (!enable_i) begin
            fs_q <= F_IDLE;
          end else if (vs_rise) begin
            fs_q      <= F_CAPTURE;
            base_q    <= start_addr_i;
            fsize_q   <= frame_size_i;
            blen_q    <= burst_len_i;
            pushed_q  <= '0;
            dropped_q <= '0;
          end
        end
        F_CAPTURE: begin
          if (!enable_i) fs_q <= F_FLUSH;
          else if (last_word) fs_q <= F_DRAIN;
        end
        F_DRAIN: begin
          if (!enable_i) begin
            fs_q <= F_FLUSH;
          end else if (drain_done) begin
            fs_q   <= F_ARMED;
            done_q <= 1'b1;
          end
        end
        F_FLUSH: begin
          if (ws_q == W_IDLE) fs_q <= F_IDLE;
        end
        default: fs_q <= F_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ws_q      <= W_IDLE;
      widx_q    <= '0;
      aw_addr_q <= '0;
      aw_len_q  <= '0;
      aw_size_q <= '0;
      wcnt_q    <= '0;
    end else begin
      unique case (ws_q)
        W_IDLE: begin
          if (arm_go) widx_q <= '0;
          if (issue) begin
            ws_q      <= W_AW;
            aw_addr_q <= base_q
                         + (AXIAddrWidth'(widx_q) << ShAmt);
            aw_len_q  <= 8'(beats - 32'd1);
            aw_size_q <= AxSize;
            widx_q    <= widx_q + beats;
            wcnt_q    <= '0;
          end
        end
        W_AW: begin
          if (axi_resp_i.aw_ready) ws_q <= W_W;
        end
        W_W: begin
          if (pop) begin
            if (wcnt_q == aw_len_q) ws_q <= W_B;
            else wcnt_q <= wcnt_q + 8'd1;
          end
        end
        W_B: begin
          if (axi_resp_i.b_valid) ws_q <= W_IDLE;
        end
        default: ws_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        wptr_q <= (wptr_q == PtrW'(FifoDepth - 1))
                  ? '0 : wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= (rptr_q == PtrW'(FifoDepth - 1))
                  ? '0 : rptr_q + 1'b1;
      end
      cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= word;
  end

  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw_valid = ws_q == W_AW;
    axi_req_o.aw_addr  = aw_addr_q;
    axi_req_o.aw_len   = aw_len_q;
    axi_req_o.aw_size  = aw_size_q;
    axi_req_o.aw_burst = (ws_q == W_AW) ? 2'b01 : 2'b00;
    axi_req_o.w_valid  = w_valid;
    axi_req_o.w_data   = w_valid ? mem_q[rptr_q] : '0;
    axi_req_o.w_strb   = w_valid ? '1 : '0;
    axi_req_o.w_last   = w_valid && (wcnt_q == aw_len_q);
    axi_req_o.b_ready  = ws_q == W_B;
  end

  assign busy_o = (fs_q == F_CAPTURE) || (fs_q == F_DRAIN)
                  || (fs_q == F_FLUSH) || (ws_q != W_IDLE);
  assign frame_done_o = done_q;
  assign overflow_o   = ovf_q;
  assign error_o      = err_q;

endmodule
